// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM states,
// latched instruction kinds, branch condition codes and the control word.
package mc_ctrl_pkg;

  localparam logic [4:0] OP_ALU = 5'b00000;
  localparam logic [4:0] OP_LHI = 5'b00001;
  localparam logic [4:0] OP_LLI = 5'b00010;
  localparam logic [4:0] OP_LD  = 5'b00011;
  localparam logic [4:0] OP_ST  = 5'b00100;
  localparam logic [4:0] OP_BCC = 5'b00101;
  localparam logic [4:0] OP_JMP = 5'b00110;
  localparam logic [4:0] OP_HLT = 5'b11111;

  localparam logic [1:0] CC_Z  = 2'b00;
  localparam logic [1:0] CC_N  = 2'b01;
  localparam logic [1:0] CC_C  = 2'b10;
  localparam logic [1:0] CC_AL = 2'b11;

  typedef enum logic [2:0] {
    IDLE_STEP, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  // LHI and LLI drive identical strobes, so they share one kind.
  typedef enum logic [2:0] {
    K_ALU, K_LI, K_LD, K_ST, K_BCC, K_JMP, K_HLT, K_BAD
  } op_kind_t;

  typedef struct packed {
    logic       buff_pc;
    logic       buff_memins;
    logic       buff_psw;
    logic       we_mem;
    logic       we_rf;
    logic       mem_res;
    logic       rb_res;
    logic       wb_res;
    logic       pc1_or_wb;
    logic       oprand_b;
    logic       li;
    logic       li_or_mov;
    logic       alu_or_not;
    logic       alu_op;
    logic       flag;
    logic       branch;
    logic [1:0] jump;
  } ctrl_t;

  // nzc is {N,Z,C}.
  function automatic logic cond_met(input logic [1:0] cc, input logic [2:0] nzc);
    logic hit;
    case (cc)
      CC_Z:    hit = nzc[1];
      CC_N:    hit = nzc[2];
      CC_C:    hit = nzc[0];
      default: hit = 1'b1;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore control-word decoder: state plus latched instruction kind (and, for
// BCC/JMP, the live condition select and flags) map to the datapath strobes.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  op_kind_t   kind,
  input  logic [1:0] alu_sel,
  input  logic [2:0] nzc,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: ctrl.buff_memins = 1'b1;
      EXEC: begin
        case (kind)
          K_ALU: begin
            ctrl.buff_psw   = 1'b1;
            ctrl.alu_or_not = 1'b1;
            ctrl.flag       = 1'b1;
          end
          K_LI: begin
            ctrl.li         = 1'b1;
            ctrl.alu_or_not = 1'b1;
            ctrl.flag       = 1'b1;
          end
          K_BCC: begin
            ctrl.buff_pc = 1'b1;
            ctrl.branch  = cond_met(alu_sel, nzc);
          end
          K_JMP: begin
            ctrl.buff_pc = 1'b1;
            ctrl.jump    = (alu_sel == 2'b00) ? 2'b01 : alu_sel;
          end
          default: ;
        endcase
      end
      MEM: begin
        if (kind == K_LD) begin
          ctrl.mem_res = 1'b1;
        end else if (kind == K_ST) begin
          ctrl.we_mem  = 1'b1;
          ctrl.rb_res  = 1'b1;
          ctrl.buff_pc = 1'b1;
        end
      end
      WB: begin
        ctrl.we_rf     = 1'b1;
        ctrl.buff_pc   = 1'b1;
        ctrl.wb_res    = (kind == K_LD);
        ctrl.li_or_mov = (kind == K_LI);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, traps HLT and
// undefined opcodes, optionally single-steps, and counts retired instructions.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W   = 5,
  parameter int CNT_W   = 16,
  parameter bit STEP_EN = 1'b0
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic [1:0]       ALUopcode,
  input  logic [2:0]       PSW_NZC,
  input  logic             step,
  output logic             Buff_PC,
  output logic             Buff_MEMIns,
  output logic             Buff_PSW,
  output logic             WE_MEM,
  output logic             WE_RF,
  output logic             MEMresource,
  output logic             RBresource,
  output logic             WBresource,
  output logic             PCplus1orWB,
  output logic             oprandB,
  output logic             LI,
  output logic             LIorMOV,
  output logic             ALUorNot,
  output logic             ALUop,
  output logic             Flag,
  output logic             Branch,
  output logic [1:0]       Jump,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt,
  output state_t           fsm_state
);

  localparam state_t RETIRE_TO = STEP_EN ? IDLE_STEP : FETCH;

  state_t           state, state_nxt;
  op_kind_t         kind_q, kind_now;
  ctrl_t            ctrl_raw, ctrl;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    case (opcode)
      OPC_W'(OP_ALU): kind_now = K_ALU;
      OPC_W'(OP_LHI): kind_now = K_LI;
      OPC_W'(OP_LLI): kind_now = K_LI;
      OPC_W'(OP_LD):  kind_now = K_LD;
      OPC_W'(OP_ST):  kind_now = K_ST;
      OPC_W'(OP_BCC): kind_now = K_BCC;
      OPC_W'(OP_JMP): kind_now = K_JMP;
      OPC_W'(OP_HLT): kind_now = K_HLT;
      default:        kind_now = K_BAD;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE_STEP: if (step) state_nxt = FETCH;
      FETCH:     state_nxt = DECODE;
      DECODE:    state_nxt = (kind_now == K_HLT || kind_now == K_BAD) ? HALT : EXEC;
      EXEC: begin
        case (kind_q)
          K_ALU, K_LI: state_nxt = WB;
          K_LD, K_ST:  state_nxt = MEM;
          default:     state_nxt = RETIRE_TO;
        endcase
      end
      MEM:     state_nxt = (kind_q == K_LD) ? WB : RETIRE_TO;
      WB:      state_nxt = RETIRE_TO;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state     <= RETIRE_TO;
      kind_q    <= K_ALU;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state <= state_nxt;
      if (state == DECODE) begin
        kind_q <= kind_now;
        if (kind_now == K_BAD) illegal_q <= 1'b1;
      end
      if (ctrl.buff_pc && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  mc_ctrl_decode u_decode (
    .state   (state),
    .kind    (kind_q),
    .alu_sel (ALUopcode),
    .nzc     (PSW_NZC),
    .ctrl    (ctrl_raw)
  );

  // Gating with Rst makes an abandoned instruction write nothing in the reset cycle.
  assign ctrl = Rst ? '0 : ctrl_raw;

  assign Buff_PC     = ctrl.buff_pc;
  assign Buff_MEMIns = ctrl.buff_memins;
  assign Buff_PSW    = ctrl.buff_psw;
  assign WE_MEM      = ctrl.we_mem;
  assign WE_RF       = ctrl.we_rf;
  assign MEMresource = ctrl.mem_res;
  assign RBresource  = ctrl.rb_res;
  assign WBresource  = ctrl.wb_res;
  assign PCplus1orWB = ctrl.pc1_or_wb;
  assign oprandB     = ctrl.oprand_b;
  assign LI          = ctrl.li;
  assign LIorMOV     = ctrl.li_or_mov;
  assign ALUorNot    = ctrl.alu_or_not;
  assign ALUop       = ctrl.alu_op;
  assign Flag        = ctrl.flag;
  assign Branch      = ctrl.branch;
  assign Jump        = ctrl.jump;
  assign halted      = (state == HALT);
  assign illegal     = illegal_q;
  assign instr_cnt   = cnt_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: three instances (free-running, single-step, 2-bit
// counter) checked against a per-instruction strobe table kept in exp_q.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  localparam int W = 36;
  localparam int B_PC = 15, B_MI = 14, B_PSW = 13, B_WM = 12, B_WR = 11, B_MR = 10;
  localparam int B_RR = 9, B_WBR = 8, B_LI = 5, B_LM = 4, B_AN = 3, B_FL = 1, B_BR = 0;

  logic         clk = 1'b0;
  logic [2:0]   rst_v = 3'b111;
  logic [4:0]   opcode = 5'b0;
  logic [1:0]   alu_sel = 2'b0;
  logic [2:0]   psw = 3'b0;
  logic         step = 1'b0;
  logic [W-1:0] vec [3];
  logic [2:0]   both_we;

  logic [W-1:0] exp_q[$];
  int           sel = 0;
  int           total = 0;
  int           bad = 0;
  logic [15:0]  cnt_m = '0;
  logic [15:0]  cnt_max = 16'hffff;
  logic         halted_m = 1'b0;
  logic         illegal_m = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 2) ? 2 : 16;
    logic [CW-1:0] cnt;
    logic [1:0]    jump;
    logic          b_pc, b_mi, b_psw, we_mem, we_rf, mem_res, rb_res, wb_res;
    logic          pc1, opb, li, limov, alun, aluop, flag, branch, hlt, ill;
    state_t        st;

    mc_ctrl_fsm #(.OPC_W(5), .CNT_W(CW), .STEP_EN(g == 1)) dut (
      .clk(clk), .Rst(rst_v[g]), .opcode(opcode), .ALUopcode(alu_sel),
      .PSW_NZC(psw), .step(step), .Buff_PC(b_pc), .Buff_MEMIns(b_mi),
      .Buff_PSW(b_psw), .WE_MEM(we_mem), .WE_RF(we_rf), .MEMresource(mem_res),
      .RBresource(rb_res), .WBresource(wb_res), .PCplus1orWB(pc1),
      .oprandB(opb), .LI(li), .LIorMOV(limov), .ALUorNot(alun), .ALUop(aluop),
      .Flag(flag), .Branch(branch), .Jump(jump), .halted(hlt), .illegal(ill),
      .instr_cnt(cnt), .fsm_state(st)
    );

    assign vec[g] = {16'(cnt), ill, hlt, jump, b_pc, b_mi, b_psw, we_mem, we_rf,
                     mem_res, rb_res, wb_res, pc1, opb, li, limov, alun, aluop,
                     flag, branch};
    assign both_we[g] = we_mem & we_rf;
  end

  // Scoreboard: one expected word per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      total++;
      if (vec[sel] !== e) begin
        bad++;
        $display("FAIL ctl dut=%0d t=%0t got=%h exp=%h", sel, $time, vec[sel], e);
      end
      total++;
      if (both_we[sel] !== 1'b0) begin
        bad++;
        $display("FAIL we_excl dut=%0d t=%0t got=%b exp=0", sel, $time, both_we[sel]);
      end
    end
  end

  function automatic logic [17:0] b(input int i);
    return 18'(1) << i;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, want);
    end
  endtask

  task automatic cyc(input logic [17:0] w);
    exp_q.push_back({cnt_m, illegal_m, halted_m, w});
    @(posedge clk);
    #1;
    if (w[B_PC] && cnt_m != cnt_max) cnt_m = cnt_m + 16'd1;
  endtask

  task automatic do_reset(input int n);
    rst_v[sel] = 1'b1;
    @(posedge clk);
    #1;
    cnt_m = '0;
    halted_m = 1'b0;
    illegal_m = 1'b0;
    repeat (n - 1) cyc('0);
    rst_v[sel] = 1'b0;
  endtask

  // Strobe table per instruction class, one entry per cycle.
  task automatic do_instr(input logic [4:0] opc, input logic [1:0] s, input logic [2:0] nzc);
    logic [17:0] w[$];
    logic        taken;
    logic        stop;
    opcode = opc;
    alu_sel = s;
    psw = nzc;
    stop = 1'b0;
    w.push_back(b(B_MI));
    w.push_back('0);
    case (opc)
      5'b00000: begin
        w.push_back(b(B_PSW) | b(B_AN) | b(B_FL));
        w.push_back(b(B_WR) | b(B_PC));
      end
      5'b00001, 5'b00010: begin
        w.push_back(b(B_LI) | b(B_AN) | b(B_FL));
        w.push_back(b(B_WR) | b(B_PC) | b(B_LM));
      end
      5'b00011: begin
        w.push_back('0);
        w.push_back(b(B_MR));
        w.push_back(b(B_WR) | b(B_WBR) | b(B_PC));
      end
      5'b00100: begin
        w.push_back('0);
        w.push_back(b(B_WM) | b(B_RR) | b(B_PC));
      end
      5'b00101: begin
        taken = (s == 2'd0) ? nzc[1] : (s == 2'd1) ? nzc[2] : (s == 2'd2) ? nzc[0] : 1'b1;
        w.push_back(b(B_PC) | (taken ? b(B_BR) : 18'd0));
      end
      5'b00110: w.push_back({(s == 2'd0) ? 2'b01 : s, 16'h0000} | b(B_PC));
      default: stop = 1'b1;
    endcase
    foreach (w[i]) cyc(w[i]);
    if (stop) begin
      halted_m = 1'b1;
      illegal_m = (opc != 5'b11111);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Free-running instance.
    sel = 0;
    do_reset(3);
    chk("rst_cnt", vec[0][35:20], 16'd0);
    chk("rst_ill", {15'd0, vec[0][19]}, 16'd0);
    do_instr(5'b00000, 2'b01, 3'b000);
    chk("alu_cnt", vec[0][35:20], 16'd1);
    do_instr(5'b00001, 2'b00, 3'b000);
    do_instr(5'b00010, 2'b00, 3'b111);
    do_instr(5'b00011, 2'b10, 3'b000);
    do_instr(5'b00100, 2'b00, 3'b000);
    chk("ldst_cnt", vec[0][35:20], 16'd5);
    do_instr(5'b00101, 2'b00, 3'b010);
    do_instr(5'b00101, 2'b00, 3'b000);
    do_instr(5'b00101, 2'b01, 3'b100);
    do_instr(5'b00101, 2'b10, 3'b001);
    do_instr(5'b00101, 2'b10, 3'b110);
    do_instr(5'b00101, 2'b11, 3'b000);
    do_instr(5'b00110, 2'b00, 3'b000);
    do_instr(5'b00110, 2'b10, 3'b000);
    do_instr(5'b00110, 2'b11, 3'b000);
    chk("br_cnt", vec[0][35:20], 16'd14);
    do_instr(5'b11111, 2'b00, 3'b000);
    opcode = 5'b00000;
    repeat (20) cyc('0);
    chk("hlt_cnt", vec[0][35:20], 16'd14);
    chk("hlt_halted", {15'd0, vec[0][18]}, 16'd1);
    chk("hlt_ill", {15'd0, vec[0][19]}, 16'd0);
    do_reset(2);
    do_instr(5'b01111, 2'b00, 3'b000);
    repeat (5) cyc('0);
    chk("bad_ill", {15'd0, vec[0][19]}, 16'd1);
    do_reset(2);
    do_instr(5'b00000, 2'b00, 3'b000);
    chk("post_cnt", vec[0][35:20], 16'd1);
    rst_v[0] = 1'b1;

    // Single-step instance.
    sel = 1;
    do_reset(2);
    repeat (10) cyc('0);
    step = 1'b1;
    cyc('0);
    do_instr(5'b00000, 2'b00, 3'b000);
    step = 1'b0;
    repeat (3) cyc('0);
    step = 1'b1;
    cyc('0);
    do_instr(5'b00011, 2'b00, 3'b000);
    step = 1'b0;
    chk("step_cnt", vec[1][35:20], 16'd2);
    repeat (2) cyc('0);
    step = 1'b1;
    cyc('0);
    step = 1'b0;
    opcode = 5'b00011;
    cyc(b(B_MI));
    cyc('0);
    cyc('0);
    rst_v[1] = 1'b1;
    cyc('0);
    cnt_m = '0;
    rst_v[1] = 1'b0;
    repeat (3) cyc('0);
    chk("midrst_cnt", vec[1][35:20], 16'd0);
    rst_v[1] = 1'b1;

    // Two-bit counter instance.
    sel = 2;
    cnt_max = 16'd3;
    do_reset(2);
    repeat (5) do_instr(5'b00000, 2'b00, 3'b000);
    chk("sat_cnt", vec[2][35:20], 16'd3);

    @(negedge clk);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
